// File: rtl/pe_accumulator.sv
// Saturating dot-product accumulator: sums N_TERMS unsigned 16-bit products per group
// and presents each group result through a one-entry output register.
module pe_accumulator #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 24,
  localparam int CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             prod_valid,
  input  logic [15:0]      prod_in,
  output logic             prod_ready,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_sat
);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_acc;

  logic             last;
  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic             ovf;
  logic [ACC_W-1:0] nxt;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // prod_ready never looks at prod_valid; only the final term of a group can
  // stall, and only while an undrained result still occupies the output register.
  assign last       = (cnt == CNT_W'(N_TERMS - 1));
  assign prod_ready = !clear && !(last && sum_valid && !sum_ready);
  assign accept     = prod_valid && prod_ready;

  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(prod_in);
  assign ovf     = sum_ext[ACC_W];
  assign nxt     = ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      sat_acc   <= 1'b0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
      sum_sat   <= 1'b0;
    end else begin
      if (clear) begin
        acc     <= '0;
        cnt     <= '0;
        sat_acc <= 1'b0;
      end else if (accept) begin
        if (last) begin
          acc     <= '0;
          cnt     <= '0;
          sat_acc <= 1'b0;
          sum_out <= nxt;
          sum_sat <= sat_acc | ovf;
        end else begin
          acc     <= nxt;
          cnt     <= cnt + CNT_W'(1);
          sat_acc <= sat_acc | ovf;
        end
      end

      // A new result loading in the same cycle as a drain keeps valid high.
      if (accept && last) begin
        sum_valid <= 1'b1;
      end else if (sum_ready) begin
        sum_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed plus random checks of pe_accumulator against a bench-side group model
// whose completed sums wait in an expected queue until the DUT presents them.
module tb_pe_accumulator;

  localparam int N = 4;
  localparam int W = 17;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          prod_valid;
  logic [15:0]   prod_in;
  logic          prod_ready;
  logic          sum_valid;
  logic          sum_ready;
  logic [W-1:0]  sum_out;
  logic          sum_sat;

  int checks = 0;
  int errors = 0;

  // expected queue entries: {sat, sum}
  logic [W:0]    exp_q[$];
  logic [W-1:0]  m_acc;
  int            m_cnt;
  logic          m_sat;

  pe_accumulator #(.N_TERMS(N), .ACC_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .prod_ready (prod_ready),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_out    (sum_out),
    .sum_sat    (sum_sat)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    m_acc = '0;
    m_cnt = 0;
    m_sat = 1'b0;
  endtask

  // Drive one cycle starting at a falling edge; compare, update model, advance.
  task automatic step(input logic pv, input logic [15:0] pd, input logic sr, input logic clr);
    logic         exp_rdy;
    logic         last;
    logic         ovf;
    logic [W:0]   ext;
    logic [W-1:0] nxt;
    prod_valid = pv;
    prod_in    = pd;
    sum_ready  = sr;
    clear      = clr;
    #1;
    last    = (m_cnt == N - 1);
    exp_rdy = !clr && !(last && (exp_q.size() != 0) && !sr);
    check("prod_ready", 32'(prod_ready), 32'(exp_rdy));
    check("sum_valid", 32'(sum_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("sum_out", 32'(sum_out), 32'(exp_q[0][W-1:0]));
      check("sum_sat", 32'(sum_sat), 32'(exp_q[0][W]));
      if (sr) void'(exp_q.pop_front());
    end
    if (clr) begin
      model_zero();
    end else if (pv && exp_rdy) begin
      ext = {1'b0, m_acc} + (W + 1)'(pd);
      ovf = ext[W];
      nxt = ovf ? {W{1'b1}} : ext[W-1:0];
      if (last) begin
        exp_q.push_back({m_sat | ovf, nxt});
        model_zero();
      end else begin
        m_acc = nxt;
        m_cnt++;
        m_sat = m_sat | ovf;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int edges);
    rst        = 1'b1;
    clear      = 1'b0;
    prod_valid = 1'b0;
    prod_in    = '0;
    sum_ready  = 1'b0;
    repeat (edges) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    exp_q.delete();
    model_zero();
    #1;
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_sum_out", 32'(sum_out), 32'd0);
    check("rst_sum_sat", 32'(sum_sat), 32'd0);
    check("rst_prod_ready", 32'(prod_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] basic[4];
    basic = '{16'd12, 16'd200, 16'd3, 16'd1};
    @(negedge clk);
    do_reset(2);

    // basic group: 12+200+3+1 = 216, valid for exactly one cycle
    for (int i = 0; i < 4; i++) step(1'b1, basic[i], 1'b1, 1'b0);
    check("basic_sum", 32'(sum_out), 32'd216);
    step(1'b0, 16'd0, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0);

    // saturation, then a clean group right after
    for (int i = 0; i < 4; i++) step(1'b1, 16'd65025, 1'b1, 1'b0);
    check("sat_sum", 32'(sum_out), 32'd131071);
    check("sat_flag", 32'(sum_sat), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'd1, 1'b1, 1'b0);
    check("post_sat_sum", 32'(sum_out), 32'd4);
    check("post_sat_flag", 32'(sum_sat), 32'd0);
    step(1'b0, 16'd0, 1'b1, 1'b0);

    // backpressure: group A = 10 held, group B = 5,5,5,5 streamed
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'd5, 1'b0, 1'b0);
    check("bp_stall_ready", 32'(prod_ready), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'd5, 1'b0, 1'b0);
    check("bp_hold_sum", 32'(sum_out), 32'd10);
    step(1'b1, 16'd5, 1'b1, 1'b0);
    check("bp_new_sum", 32'(sum_out), 32'd20);
    step(1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0);

    // clear: pending A = 10 survives; 7,9 and 100 are discarded
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'd7, 1'b0, 1'b0);
    step(1'b1, 16'd9, 1'b0, 1'b0);
    step(1'b1, 16'd100, 1'b0, 1'b1);
    check("clr_pending_sum", 32'(sum_out), 32'd10);
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    check("clr_result", 32'(sum_out), 32'd10);
    step(1'b0, 16'd0, 1'b1, 1'b0);

    // reset mid-group with a pending result, then 8 fresh products
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'd5, 1'b0, 1'b0);
    step(1'b1, 16'd6, 1'b0, 1'b0);
    do_reset(2);
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    check("post_rst_group2", 32'(sum_out), 32'd26);
    step(1'b0, 16'd0, 1'b1, 1'b0);

    // random traffic through the multiplier model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] p;
      p = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
      step(1'($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
